// File: rtl/jpc_control_pkg.sv
// Shared constants for the JPC sequencer: opcodes, FSM state encoding,
// PC-source codes and trap causes.
package jpc_control_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_REL   = 2'b01,
        PC_JALR  = 2'b10
    } pc_sel_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_ILLEGAL = 3'd1,
        CAUSE_ECALL   = 3'd2,
        CAUSE_EBREAK  = 3'd3,
        CAUSE_IMEM_TO = 3'd4,
        CAUSE_DMEM_TO = 3'd5
    } trap_cause_e;

    // Opcodes that produce a destination-register result.
    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_OP, OP_OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

endpackage

// File: rtl/jpc_control_req_timer.sv
// Memory-request watchdog shared by the fetch and data-access phases;
// expired_O fires on the last allowed wait cycle unless ack arrives with it.
module jpc_req_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TCW     = 8
) (
    input  logic clk_I,
    input  logic rst_I,
    input  logic clear_I,
    input  logic run_I,
    input  logic ack_I,
    output logic expired_O
);

    localparam logic [TCW:0] LIMIT   = (TCW+1)'(TIMEOUT);
    localparam bit           ENABLED = (TIMEOUT != 0);

    logic [TCW-1:0] cnt_q, cnt_d;
    logic           hits_limit;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_I) begin
            cnt_d = '0;
        end else if (run_I && !ack_I) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q counts wait cycles already spent; this cycle would be the next one.
    assign hits_limit = (({1'b0, cnt_q} + {{TCW{1'b0}}, 1'b1}) == LIMIT);
    assign expired_O  = ENABLED && run_I && !ack_I && hits_limit;

    // NOTE: state uses non-blocking assignments; reset here is synchronous and active-high.
    always_ff @(posedge clk_I) begin
        if (rst_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jpc_control.sv
// Multi-cycle sequencer for the JPC core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with a sticky TRAP state on decoder faults and memory timeouts.
module jpc_control
    import jpc_control_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TCW     = 8
) (
    input  logic       clk_I,
    input  logic       rst_I,
    input  logic [6:0] opcode_I,
    input  logic       ecall_I,
    input  logic       ebreak_I,
    input  logic       fence_I,
    input  logic       fence_i_I,
    input  logic       error_I,
    input  logic       branch_taken_I,
    input  logic       imem_ack_I,
    input  logic       dmem_ack_I,
    output logic       imem_req_O,
    output logic       ir_we_O,
    output logic       dmem_req_O,
    output logic       dmem_we_O,
    output logic       rf_we_O,
    output logic       pc_we_O,
    output logic [1:0] pc_sel_O,
    output logic       retire_O,
    output logic       halt_O,
    output logic [2:0] trap_cause_O
);

    state_e      state_q, state_d;
    trap_cause_e cause_q, cause_d;
    pc_sel_e     pc_sel;
    logic        req_ack;
    logic        timer_clear;
    logic        timer_expired;

    assign req_ack     = (state_q == ST_FETCH) ? imem_ack_I : dmem_ack_I;
    assign timer_clear = (state_d != state_q) && (state_d == ST_FETCH || state_d == ST_MEM);

    jpc_req_timer #(
        .TIMEOUT (TIMEOUT),
        .TCW     (TCW)
    ) u_req_timer (
        .clk_I     (clk_I),
        .rst_I     (rst_I),
        .clear_I   (timer_clear),
        .run_I     (imem_req_O || dmem_req_O),
        .ack_I     (req_ack),
        .expired_O (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req_O = 1'b0;
        ir_we_O    = 1'b0;
        dmem_req_O = 1'b0;
        dmem_we_O  = 1'b0;
        rf_we_O    = 1'b0;
        pc_we_O    = 1'b0;
        retire_O   = 1'b0;
        halt_O     = 1'b0;
        pc_sel     = PC_PLUS4;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;

            ST_FETCH: begin
                imem_req_O = 1'b1;
                ir_we_O    = imem_ack_I;
                if (imem_ack_I) begin
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end

            ST_DECODE: begin
                if (error_I) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (ecall_I) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ECALL;
                end else if (ebreak_I) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_EBREAK;
                end else if (fence_I || fence_i_I) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                if (opcode_I == OP_LOAD || opcode_I == OP_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end

            ST_MEM: begin
                dmem_req_O = 1'b1;
                dmem_we_O  = (opcode_I == OP_STORE);
                if (dmem_ack_I) begin
                    state_d = ST_WRITEBACK;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end

            ST_WRITEBACK: begin
                pc_we_O  = 1'b1;
                retire_O = 1'b1;
                rf_we_O  = writes_rd(opcode_I);
                if (opcode_I == OP_JAL || (opcode_I == OP_BRANCH && branch_taken_I)) begin
                    pc_sel = PC_REL;
                end else if (opcode_I == OP_JALR) begin
                    pc_sel = PC_JALR;
                end
                state_d = ST_FETCH;
            end

            ST_TRAP: halt_O = 1'b1;

            default: state_d = ST_RESET;
        endcase
    end

    assign pc_sel_O     = pc_sel;
    assign trap_cause_O = cause_q;

    always_ff @(posedge clk_I) begin
        if (rst_I) begin
            state_q <= ST_RESET;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_jpc_control.sv
// Directed bench for jpc_control: per-cycle comparison of the packed output
// vector against hand-written expectations for each instruction class.
module tb_jpc_control;
    import jpc_control_pkg::*;

    logic       clk_I = 1'b0;
    logic       rst_I = 1'b1;
    logic [6:0] opcode_I = '0;
    logic       ecall_I = 1'b0, ebreak_I = 1'b0, fence_I = 1'b0, fence_i_I = 1'b0, error_I = 1'b0;
    logic       branch_taken_I = 1'b0;
    logic       imem_ack_I = 1'b0, dmem_ack_I = 1'b0;
    logic       imem_req_O, ir_we_O, dmem_req_O, dmem_we_O, rf_we_O, pc_we_O, retire_O, halt_O;
    logic [1:0] pc_sel_O;
    logic [2:0] trap_cause_O;
    logic [12:0] obs;

    int checks = 0;
    int errors = 0;

    jpc_control #(.TIMEOUT(4), .TCW(8)) dut (
        .clk_I          (clk_I),
        .rst_I          (rst_I),
        .opcode_I       (opcode_I),
        .ecall_I        (ecall_I),
        .ebreak_I       (ebreak_I),
        .fence_I        (fence_I),
        .fence_i_I      (fence_i_I),
        .error_I        (error_I),
        .branch_taken_I (branch_taken_I),
        .imem_ack_I     (imem_ack_I),
        .dmem_ack_I     (dmem_ack_I),
        .imem_req_O     (imem_req_O),
        .ir_we_O        (ir_we_O),
        .dmem_req_O     (dmem_req_O),
        .dmem_we_O      (dmem_we_O),
        .rf_we_O        (rf_we_O),
        .pc_we_O        (pc_we_O),
        .pc_sel_O       (pc_sel_O),
        .retire_O       (retire_O),
        .halt_O         (halt_O),
        .trap_cause_O   (trap_cause_O)
    );

    always #5 clk_I = ~clk_I;

    assign obs = {imem_req_O, ir_we_O, dmem_req_O, dmem_we_O, rf_we_O, pc_we_O,
                  pc_sel_O, retire_O, halt_O, trap_cause_O};

    // Field order: imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, halt, cause
    function automatic logic [12:0] o(input bit ireq, input bit irw, input bit dreq, input bit dwe,
                                      input bit rf, input bit pcw, input bit [1:0] sel,
                                      input bit ret, input bit hlt, input bit [2:0] c);
        return {ireq, irw, dreq, dwe, rf, pcw, sel, ret, hlt, c};
    endfunction
    function automatic logic [12:0] fw();  return o(1,0,0,0,0,0,2'd0,0,0,3'd0); endfunction
    function automatic logic [12:0] fa();  return o(1,1,0,0,0,0,2'd0,0,0,3'd0); endfunction
    function automatic logic [12:0] idl(); return 13'd0; endfunction
    function automatic logic [12:0] mr(input bit we); return o(0,0,1,we,0,0,2'd0,0,0,3'd0); endfunction
    function automatic logic [12:0] wb(input bit rf, input bit [1:0] sel);
        return o(0,0,0,0,rf,1,sel,1,0,3'd0);
    endfunction
    function automatic logic [12:0] tr(input bit [2:0] c); return o(0,0,0,0,0,0,2'd0,0,1,c); endfunction

    task automatic set_dec(input logic [6:0] op, input bit err, input bit ec, input bit eb,
                           input bit fn, input bit fni, input bit taken);
        opcode_I = op; error_I = err; ecall_I = ec; ebreak_I = eb;
        fence_I = fn; fence_i_I = fni; branch_taken_I = taken;
    endtask

    // Leaves the bench one step after an edge with the DUT in its first FETCH cycle.
    task automatic do_reset();
        rst_I = 1'b1; imem_ack_I = 1'b0; dmem_ack_I = 1'b0;
        repeat (2) @(posedge clk_I);
        #1 rst_I = 1'b0;
        @(posedge clk_I); #1;
    endtask

    task automatic test_reset();
        rst_I = 1'b1;
        repeat (3) @(posedge clk_I);
        #2;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 13'd0); end
        rst_I = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_state_idle: got %b expected %b", obs, 13'd0); end
        @(posedge clk_I); #1;
        checks++;
        if (obs !== fw()) begin errors++; $display("FAIL first_fetch: got %b expected %b", obs, fw()); end
    endtask

    task automatic test_addi();
        logic [12:0] ev [5];
        bit          ia [5];
        do_reset();
        set_dec(OP_OP_IMM, 0, 0, 0, 0, 0, 0);
        ev = '{fa(), idl(), idl(), wb(1, 2'd0), fa()};
        ia = '{1, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            imem_ack_I = ia[i]; dmem_ack_I = 1'b0;
            #1;
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL addi cycle %0d: got %b expected %b", i + 1, obs, ev[i]); end
            @(posedge clk_I); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [12:0] ev [9];
        bit          da [9];
        do_reset();
        set_dec(OP_LOAD, 0, 0, 0, 0, 0, 0);
        ev = '{fa(), idl(), idl(), mr(0), mr(0), mr(0), mr(0), wb(1, 2'd0), fw()};
        da = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            imem_ack_I = (i == 0); dmem_ack_I = da[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL load_wait cycle %0d: got %b expected %b", i + 1, obs, ev[i]); end
            @(posedge clk_I); #1;
        end
    endtask

    task automatic test_store();
        logic [12:0] ev [6];
        bit          da [6];
        do_reset();
        set_dec(OP_STORE, 0, 0, 0, 0, 0, 0);
        // Acks during DECODE/EXECUTE must be ignored.
        ev = '{fa(), idl(), idl(), mr(1), wb(0, 2'd0), fw()};
        da = '{0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            imem_ack_I = (i == 0); dmem_ack_I = da[i];
            #1;
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL store cycle %0d: got %b expected %b", i + 1, obs, ev[i]); end
            @(posedge clk_I); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops   [4];
        bit          taken [4];
        logic [12:0] last  [4];
        logic [12:0] ev;
        do_reset();
        ops   = '{OP_BRANCH, OP_BRANCH, OP_JAL, OP_JALR};
        taken = '{1, 0, 0, 0};
        last  = '{wb(0, 2'd1), wb(0, 2'd0), wb(1, 2'd1), wb(1, 2'd2)};
        for (int k = 0; k < 4; k++) begin
            set_dec(ops[k], 0, 0, 0, 0, 0, taken[k]);
            for (int i = 0; i < 4; i++) begin
                imem_ack_I = (i == 0); dmem_ack_I = 1'b0;
                ev = (i == 0) ? fa() : (i == 3) ? last[k] : idl();
                #1;
                checks++;
                if (obs !== ev) begin errors++; $display("FAIL flow insn %0d cycle %0d: got %b expected %b", k, i + 1, obs, ev); end
                @(posedge clk_I); #1;
            end
        end
    endtask

    task automatic test_traps();
        bit       err [3];
        bit       ec  [3];
        bit       eb  [3];
        bit [2:0] cs  [3];
        logic [12:0] ev;
        err = '{1, 0, 0};
        ec  = '{1, 1, 0};
        eb  = '{0, 1, 1};
        cs  = '{3'd1, 3'd2, 3'd3};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            set_dec(OP_OP_IMM, err[k], ec[k], eb[k], 0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                // A late imem ack in TRAP must not restart fetching.
                imem_ack_I = (i == 0 || i == 3); dmem_ack_I = (i == 3);
                ev = (i == 0) ? fa() : (i == 1) ? idl() : tr(cs[k]);
                #1;
                checks++;
                if (obs !== ev) begin errors++; $display("FAIL trap case %0d cycle %0d: got %b expected %b", k, i + 1, obs, ev); end
                @(posedge clk_I); #1;
            end
        end
    endtask

    task automatic test_fence();
        logic [12:0] ev [4];
        ev = '{fa(), idl(), wb(0, 2'd0), fw()};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            set_dec(OP_MISC_MEM, 0, 0, 0, k == 0, k == 1, 0);
            for (int i = 0; i < 4; i++) begin
                imem_ack_I = (i == 0); dmem_ack_I = 1'b0;
                #1;
                checks++;
                if (obs !== ev[i]) begin errors++; $display("FAIL fence%0d cycle %0d: got %b expected %b", k, i + 1, obs, ev[i]); end
                @(posedge clk_I); #1;
            end
        end
    endtask

    task automatic test_imem_timeout();
        logic [12:0] ev [6];
        logic [12:0] ev2 [5];
        bit          ia [6];
        bit          ia2 [5];
        do_reset();
        set_dec(OP_OP_IMM, 0, 0, 0, 0, 0, 0);
        ev = '{fw(), fw(), fw(), fw(), tr(3'd4), tr(3'd4)};
        ia = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            imem_ack_I = ia[i]; dmem_ack_I = 1'b0;
            #1;
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL imem_timeout cycle %0d: got %b expected %b", i + 1, obs, ev[i]); end
            @(posedge clk_I); #1;
        end
        do_reset();
        ev2 = '{fw(), fw(), fw(), fa(), idl()};
        ia2 = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            imem_ack_I = ia2[i]; dmem_ack_I = 1'b0;
            #1;
            checks++;
            if (obs !== ev2[i]) begin errors++; $display("FAIL ack_at_limit cycle %0d: got %b expected %b", i + 1, obs, ev2[i]); end
            @(posedge clk_I); #1;
        end
    endtask

    task automatic test_dmem_timeout();
        logic [12:0] ev [8];
        do_reset();
        set_dec(OP_LOAD, 0, 0, 0, 0, 0, 0);
        ev = '{fa(), idl(), idl(), mr(0), mr(0), mr(0), mr(0), tr(3'd5)};
        for (int i = 0; i < 8; i++) begin
            imem_ack_I = (i == 0); dmem_ack_I = 1'b0;
            #1;
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL dmem_timeout cycle %0d: got %b expected %b", i + 1, obs, ev[i]); end
            @(posedge clk_I); #1;
        end
        rst_I = 1'b1;
        @(posedge clk_I); #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL cause_cleared: got %b expected %b", obs, 13'd0); end
        rst_I = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        logic [12:0] ev [5];
        do_reset();
        set_dec(OP_LOAD, 0, 0, 0, 0, 0, 0);
        ev = '{fa(), idl(), idl(), mr(0), mr(0)};
        for (int i = 0; i < 5; i++) begin
            imem_ack_I = (i == 0); dmem_ack_I = 1'b0;
            #1;
            checks++;
            if (obs !== ev[i]) begin errors++; $display("FAIL mid_mem cycle %0d: got %b expected %b", i + 1, obs, ev[i]); end
            @(posedge clk_I); #1;
        end
        rst_I = 1'b1;
        #1;
        checks++;
        if (obs !== mr(0)) begin errors++; $display("FAIL mid_mem_before_edge: got %b expected %b", obs, mr(0)); end
        @(posedge clk_I); #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL mid_mem_reset: got %b expected %b", obs, 13'd0); end
        rst_I = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL mid_mem_released: got %b expected %b", obs, 13'd0); end
        @(posedge clk_I); #1;
        checks++;
        if (obs !== fw()) begin errors++; $display("FAIL mid_mem_refetch: got %b expected %b", obs, fw()); end
        imem_ack_I = 1'b1;
        #1;
        checks++;
        if (obs !== fa()) begin errors++; $display("FAIL mid_mem_refetch_ack: got %b expected %b", obs, fa()); end
        @(posedge clk_I); #1;
        imem_ack_I = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_traps();
        test_fence();
        test_imem_timeout();
        test_dmem_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
